// File: rtl/hub75_pkg.sv
// hub75_pkg: shared definitions for the HUB75 driver and receiver.
// Commit FSM encoding and memory-word plane bit offsets.
package hub75_pkg;

  typedef enum logic [0:0] {
    RX_IDLE   = 1'b0,
    RX_COMMIT = 1'b1
  } rx_state_t;

  // Word layout {R,G,B}: R plane p at MDW-PD+p, G at MDW-2PD+p, B at p.
  localparam int HUB_PD_DEF  = 3;
  localparam int HUB_MDW_DEF = HUB_PD_DEF * 3;
  localparam int BIT_R0 = HUB_MDW_DEF - HUB_PD_DEF;
  localparam int BIT_G0 = HUB_MDW_DEF - 2 * HUB_PD_DEF;
  localparam int BIT_B0 = 0;

  function automatic int bit_r0(input int mdw, input int pd);
    return mdw - pd;
  endfunction

  function automatic int bit_g0(input int mdw, input int pd);
    return mdw - 2 * pd;
  endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// hub75_rx_sync: multi-flop synchroniser with one extra edge flop.
// q is the synchronised level; rise/fall compare q with one cycle later.
module hub75_rx_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] chain [STAGES];
  logic [W-1:0] prev;

  // Synchroniser chain plus edge-detect history flop
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      prev <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-side receiver rebuilding bit planes into memory.
// Ping-pong line buffer fills from SCLK while the other half commits.
module hub75_rx
  import hub75_pkg::*;
#(
  parameter int PIXEL_DEPTH        = 3,
  parameter int MEM_DATA_WIDTH     = PIXEL_DEPTH * 3,
  parameter int MAX_IMG_WIDTH_LOG2 = 9,
  parameter int MEM_ADDR_WIDTH     = 14,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [MAX_IMG_WIDTH_LOG2:0]   IMG_WIDTH,
  input  logic [5:0]                    SCAN_RATIO,
  input  logic [1:0]                    HUB_R,
  input  logic [1:0]                    HUB_G,
  input  logic [1:0]                    HUB_B,
  input  logic                          HUB_SCLK,
  input  logic                          HUB_LATCH,
  input  logic                          HUB_OE,
  input  logic [4:0]                    HUB_ADDR,
  output logic [MEM_ADDR_WIDTH-1:0]     MEM_ADDR,
  output logic                          MEM_WE,
  output logic [MEM_DATA_WIDTH-1:0]     MEM0_WDATA,
  output logic [MEM_DATA_WIDTH-1:0]     MEM1_WDATA,
  output logic [MEM_DATA_WIDTH-1:0]     MEM_WMASK,
  output logic                          FRAME_DONE,
  output logic [15:0]                   OE_CYCLES,
  output logic                          ERR_LEN,
  output logic                          ERR_DROP,
  output logic                          ERR_PLANE
);

  localparam int PD    = PIXEL_DEPTH;
  localparam int MDW   = MEM_DATA_WIDTH;
  localparam int MIWL  = MAX_IMG_WIDTH_LOG2;
  localparam int MAW   = MEM_ADDR_WIDTH;
  localparam int DEPTH = 2 ** MIWL;
  localparam int CW    = MIWL + 1;
  localparam int PW    = CW + 5;
  localparam int PLW   = $clog2(PD + 1);
  localparam int BR0   = bit_r0(MDW, PD);
  localparam int BG0   = bit_g0(MDW, PD);

  // ---------------- input synchronisers ----------------
  logic sclk_q, sclk_rise, sclk_fall;
  logic latch_q, latch_rise, latch_fall;
  logic oe_q, oe_rise, oe_fall;
  logic [10:0] dat_q, dat_rise, dat_fall;

  hub75_rx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sclk (
    .CLK(CLK), .RESET_N(RESET_N), .d(HUB_SCLK),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  hub75_rx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_latch (
    .CLK(CLK), .RESET_N(RESET_N), .d(HUB_LATCH),
    .q(latch_q), .rise(latch_rise), .fall(latch_fall)
  );

  hub75_rx_sync #(.W(1), .STAGES(SYNC_STAGES)) u_oe (
    .CLK(CLK), .RESET_N(RESET_N), .d(HUB_OE),
    .q(oe_q), .rise(oe_rise), .fall(oe_fall)
  );

  hub75_rx_sync #(.W(11), .STAGES(SYNC_STAGES)) u_dat (
    .CLK(CLK), .RESET_N(RESET_N),
    .d({HUB_ADDR, HUB_R, HUB_G, HUB_B}),
    .q(dat_q), .rise(dat_rise), .fall(dat_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{sclk_q, sclk_fall, latch_q,
                       latch_rise, dat_rise, dat_fall};

  // Buffer word {R1,G1,B1,R0,G0,B0}: upper half in the low 3 bits.
  logic [5:0] pix;
  logic [4:0] row;
  assign pix = {dat_q[5], dat_q[3], dat_q[1],
                dat_q[4], dat_q[2], dat_q[0]};
  assign row = dat_q[10:6];

  // ---------------- shift side ----------------
  logic [5:0]    lbuf [2*DEPTH];
  logic          fill_sel;
  logic [CW-1:0] col_cnt;
  logic          col_full;
  logic          shift_wr;
  logic [CW-1:0] n_now;

  assign col_full = col_cnt[MIWL];
  assign shift_wr = sclk_rise && (col_cnt < IMG_WIDTH);
  assign n_now    = col_cnt + CW'(sclk_rise && !col_full);

  // Line buffer fill port
  always_ff @(posedge CLK) begin
    if (shift_wr)
      lbuf[{fill_sel, col_cnt[MIWL-1:0]}] <= pix;
  end

  // Column counter: saturates, cleared by each latch
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      col_cnt <= '0;
    else if (latch_fall)
      col_cnt <= '0;
    else if (sclk_rise && !col_full)
      col_cnt <= col_cnt + CW'(1);
  end

  // ---------------- latch side ----------------
  rx_state_t      state_q, state_d;
  logic [PLW-1:0] plane, plane_nx;
  logic [4:0]     last_addr;
  logic           first_latch;
  logic           new_row, plane_bad, busy;
  logic           accept, start;
  logic [CW-1:0]  n_clip;
  logic [PW-1:0]  prod;

  logic [PLW-1:0] cm_plane;
  logic [4:0]     cm_row;
  logic [CW-1:0]  cm_n;
  logic [MAW-1:0] cm_base;

  assign new_row   = first_latch || (row != last_addr);
  assign plane_nx  = new_row ? '0 :
                     (plane == PLW'(PD)) ? plane :
                     plane + PLW'(1);
  assign plane_bad = (plane_nx == PLW'(PD));
  assign busy      = (state_q != RX_IDLE);
  assign accept    = latch_fall && !plane_bad && !busy;
  assign n_clip    = (n_now > IMG_WIDTH) ? IMG_WIDTH : n_now;
  assign start     = accept && (n_clip != '0);
  assign prod      = PW'(row) * PW'(IMG_WIDTH);

  // Latch handling: plane tracking, errors, half swap
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      plane       <= '0;
      last_addr   <= '0;
      first_latch <= 1'b1;
      fill_sel    <= 1'b0;
      ERR_LEN     <= 1'b0;
      ERR_DROP    <= 1'b0;
      ERR_PLANE   <= 1'b0;
      cm_plane    <= '0;
      cm_row      <= '0;
      cm_n        <= '0;
      cm_base     <= '0;
    end else if (latch_fall) begin
      plane       <= plane_nx;
      last_addr   <= row;
      first_latch <= 1'b0;
      if (n_now != IMG_WIDTH)
        ERR_LEN <= 1'b1;
      if (plane_bad)
        ERR_PLANE <= 1'b1;
      else if (busy)
        ERR_DROP <= 1'b1;
      if (accept) begin
        fill_sel <= ~fill_sel;
        cm_plane <= plane_nx;
        cm_row   <= row;
        cm_n     <= n_clip;
        cm_base  <= MAW'(prod);
      end
    end
  end

  // ---------------- commit FSM ----------------
  logic [CW-1:0] rd_col;
  logic          last_rd;
  logic          rd_en;

  assign last_rd = (rd_col == cm_n - CW'(1));

  // Commit state register
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      state_q <= RX_IDLE;
    else
      state_q <= state_d;
  end

  // Commit next state and read enable
  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (start)
          state_d = RX_COMMIT;
      end
      RX_COMMIT: begin
        rd_en = 1'b1;
        if (last_rd)
          state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  // Read column walks 0 upward through the committed half
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      rd_col <= '0;
    else if (start)
      rd_col <= '0;
    else if (rd_en)
      rd_col <= rd_col + CW'(1);
  end

  // ---------------- read pipeline ----------------
  logic [5:0]      rd_word;
  logic            rd_v;
  logic            rd_last;
  logic [MIWL-1:0] rd_col_q;

  // Line buffer read port
  always_ff @(posedge CLK) begin
    rd_word <= lbuf[{~fill_sel, rd_col[MIWL-1:0]}];
  end

  // Read-stage control tags
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      rd_v     <= 1'b0;
      rd_last  <= 1'b0;
      rd_col_q <= '0;
    end else begin
      rd_v     <= rd_en;
      rd_last  <= rd_en && last_rd;
      rd_col_q <= rd_col[MIWL-1:0];
    end
  end

  logic [MDW-1:0] w0, w1, wm;
  logic           last_row;

  assign w0 = (MDW'(rd_word[2]) << (BR0 + int'(cm_plane)))
            | (MDW'(rd_word[1]) << (BG0 + int'(cm_plane)))
            | (MDW'(rd_word[0]) << cm_plane);
  assign w1 = (MDW'(rd_word[5]) << (BR0 + int'(cm_plane)))
            | (MDW'(rd_word[4]) << (BG0 + int'(cm_plane)))
            | (MDW'(rd_word[3]) << cm_plane);
  assign wm = (MDW'(1'b1) << (BR0 + int'(cm_plane)))
            | (MDW'(1'b1) << (BG0 + int'(cm_plane)))
            | (MDW'(1'b1) << cm_plane);
  assign last_row = ({1'b0, cm_row} == SCAN_RATIO - 6'd1);

  // Registered memory write port
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      MEM_WE     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM0_WDATA <= '0;
      MEM1_WDATA <= '0;
      MEM_WMASK  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      MEM_WE     <= rd_v;
      FRAME_DONE <= rd_v && rd_last && last_row &&
                    (cm_plane == PLW'(PD - 1));
      if (rd_v) begin
        MEM_ADDR   <= cm_base + MAW'(rd_col_q);
        MEM0_WDATA <= w0;
        MEM1_WDATA <= w1;
        MEM_WMASK  <= wm;
      end
    end
  end

  // ---------------- OE monitor ----------------
  logic [15:0] oe_cnt;

  // Measure OE-high pulse width in CLK cycles
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      oe_cnt    <= '0;
      OE_CYCLES <= '0;
    end else begin
      if (oe_rise)
        oe_cnt <= 16'd1;
      else if (oe_q && oe_cnt != 16'hFFFF)
        oe_cnt <= oe_cnt + 16'd1;
      if (oe_fall)
        OE_CYCLES <= oe_cnt;
    end
  end

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: drives a HUB75 bus and checks rebuilt memory writes.
// Vector table, hand corner sequences, then a randomized section.
module tb_hub75_rx;

  localparam int W = 8;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [9:0]  IMG_WIDTH = 10'd8;
  logic [5:0]  SCAN_RATIO = 6'd4;
  logic [1:0]  HUB_R = '0, HUB_G = '0, HUB_B = '0;
  logic        HUB_SCLK = 1'b0, HUB_LATCH = 1'b0, HUB_OE = 1'b0;
  logic [4:0]  HUB_ADDR = '0;
  logic [13:0] MEM_ADDR;
  logic        MEM_WE;
  logic [8:0]  MEM0_WDATA, MEM1_WDATA, MEM_WMASK;
  logic        FRAME_DONE;
  logic [15:0] OE_CYCLES;
  logic        ERR_LEN, ERR_DROP, ERR_PLANE;

  hub75_rx dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .IMG_WIDTH(IMG_WIDTH), .SCAN_RATIO(SCAN_RATIO),
    .HUB_R(HUB_R), .HUB_G(HUB_G), .HUB_B(HUB_B),
    .HUB_SCLK(HUB_SCLK), .HUB_LATCH(HUB_LATCH),
    .HUB_OE(HUB_OE), .HUB_ADDR(HUB_ADDR),
    .MEM_ADDR(MEM_ADDR), .MEM_WE(MEM_WE),
    .MEM0_WDATA(MEM0_WDATA), .MEM1_WDATA(MEM1_WDATA),
    .MEM_WMASK(MEM_WMASK), .FRAME_DONE(FRAME_DONE),
    .OE_CYCLES(OE_CYCLES), .ERR_LEN(ERR_LEN),
    .ERR_DROP(ERR_DROP), .ERR_PLANE(ERR_PLANE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [13:0] a;
    logic [8:0]  w0;
    logic [8:0]  w1;
    logic [8:0]  m;
    logic        d;
  } wr_t;

  typedef struct {
    int n;
    int addr;
    bit icn;
    int exp_wr;
    int exp_plane;
    bit exp_done;
    bit exp_elen;
    bit exp_eplane;
  } vec_t;

  wr_t        wq[$];
  vec_t       vecs[10];
  logic [5:0] line_px [16];
  int         n_tests = 0;
  int         n_fail = 0;
  int         fd_cnt = 0;

  always @(negedge CLK) begin
    if (MEM_WE === 1'b1)
      wq.push_back('{MEM_ADDR, MEM0_WDATA, MEM1_WDATA,
                     MEM_WMASK, FRAME_DONE});
    if (FRAME_DONE === 1'b1) fd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [8:0] pbits(input logic r, input logic g,
                                       input logic b, input int p);
    return (9'(r) << (6 + p)) | (9'(g) << (3 + p)) | (9'(b) << p);
  endfunction

  task automatic pulse(input logic [5:0] px, input bit drop_latch);
    @(negedge CLK);
    HUB_SCLK = 1'b0;
    {HUB_B, HUB_G, HUB_R} = px;
    @(negedge CLK);
    @(negedge CLK);
    HUB_SCLK = 1'b1;
    if (drop_latch) HUB_LATCH = 1'b0;
    @(negedge CLK);
  endtask

  task automatic send_line(input int n, input int a, input bit icn);
    HUB_ADDR = 5'(a);
    for (int k = 0; k < n; k++) line_px[k] = 6'($urandom);
    for (int k = 0; k < n; k++) begin
      if (icn && k == n - 3) HUB_LATCH = 1'b1;
      pulse(line_px[k], icn && (k == n - 1));
    end
    @(negedge CLK);
    HUB_SCLK = 1'b0;
    if (!icn) begin
      @(negedge CLK);
      HUB_LATCH = 1'b1;
      repeat (2) @(negedge CLK);
      HUB_LATCH = 1'b0;
    end
  endtask

  task automatic check_writes(input int en, input int a, input int p,
                              input bit ed, input string nm);
    chk({nm, " count"}, wq.size(), en);
    for (int k = 0; k < wq.size() && k < en; k++) begin
      logic [5:0] px;
      px = line_px[k];
      chk($sformatf("%s addr%0d", nm, k), wq[k].a, 14'(a * W + k));
      chk($sformatf("%s w0_%0d", nm, k), wq[k].w0,
          pbits(px[0], px[2], px[4], p));
      chk($sformatf("%s w1_%0d", nm, k), wq[k].w1,
          pbits(px[1], px[3], px[5], p));
      chk($sformatf("%s mask%0d", nm, k), wq[k].m,
          pbits(1'b1, 1'b1, 1'b1, p));
      chk($sformatf("%s done%0d", nm, k), wq[k].d,
          ed && (k == en - 1));
    end
    wq.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (3) @(negedge CLK);
    RESET_N = 1'b1;
    wq.delete();
    fd_cnt = 0;
  endtask

  initial begin
    bit found;
    int run, prev_a, a, n, p, ewr;
    bit e_len, e_plane;
    int e_fd;

    vecs[0] = '{8,  1, 1, 8, 0, 0, 0, 0};
    vecs[1] = '{8,  2, 0, 8, 0, 0, 0, 0};
    vecs[2] = '{8,  2, 0, 8, 1, 0, 0, 0};
    vecs[3] = '{8,  2, 0, 8, 2, 0, 0, 0};
    vecs[4] = '{8,  2, 0, 0, 3, 0, 0, 1};
    vecs[5] = '{8,  3, 0, 8, 0, 0, 0, 1};
    vecs[6] = '{8,  3, 0, 8, 1, 0, 0, 1};
    vecs[7] = '{8,  3, 1, 8, 2, 1, 0, 1};
    vecs[8] = '{6,  0, 0, 6, 0, 0, 1, 1};
    vecs[9] = '{10, 1, 0, 8, 0, 0, 1, 1};

    repeat (4) @(negedge CLK);
    chk("rst MEM_WE", MEM_WE, 0);
    chk("rst MEM_ADDR", MEM_ADDR, 0);
    chk("rst WDATA", {MEM0_WDATA, MEM1_WDATA, MEM_WMASK}, 0);
    chk("rst FRAME_DONE", FRAME_DONE, 0);
    chk("rst OE_CYCLES", OE_CYCLES, 0);
    chk("rst ERR", {ERR_LEN, ERR_DROP, ERR_PLANE}, 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);

    for (int i = 0; i < 10; i++) begin
      send_line(vecs[i].n, vecs[i].addr, vecs[i].icn);
      repeat (30) @(negedge CLK);
      check_writes(vecs[i].exp_wr, vecs[i].addr, vecs[i].exp_plane,
                   vecs[i].exp_done, $sformatf("v%0d", i));
      chk($sformatf("v%0d ERR_LEN", i), ERR_LEN, vecs[i].exp_elen);
      chk($sformatf("v%0d ERR_PLANE", i), ERR_PLANE,
          vecs[i].exp_eplane);
      chk($sformatf("v%0d ERR_DROP", i), ERR_DROP, 0);
    end
    chk("table frame_done count", fd_cnt, 1);

    @(negedge CLK);
    HUB_OE = 1'b1;
    repeat (37) @(negedge CLK);
    HUB_OE = 1'b0;
    repeat (6) @(negedge CLK);
    chk("oe 37", OE_CYCLES, 37);
    HUB_OE = 1'b1;
    @(negedge CLK);
    HUB_OE = 1'b0;
    repeat (6) @(negedge CLK);
    chk("oe 1", OE_CYCLES, 1);

    send_line(8, 2, 0);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge CLK);
      if (MEM_WE === 1'b1) found = 1'b1;
    end
    chk("rst-mid commit started", found, 1);
    RESET_N = 1'b0;
    @(negedge CLK);
    chk("rst-mid MEM_WE", MEM_WE, 0);
    RESET_N = 1'b1;
    wq.delete();
    repeat (20) @(negedge CLK);
    chk("rst-mid no writes", wq.size(), 0);
    chk("rst-mid ERR cleared", {ERR_LEN, ERR_DROP, ERR_PLANE}, 0);
    chk("rst-mid OE_CYCLES", OE_CYCLES, 0);
    send_line(8, 2, 0);
    repeat (30) @(negedge CLK);
    check_writes(8, 2, 0, 0, "rst-mid relatch");

    send_line(8, 1, 0);
    repeat (3) @(negedge CLK);
    HUB_LATCH = 1'b1;
    repeat (2) @(negedge CLK);
    HUB_LATCH = 1'b0;
    repeat (30) @(negedge CLK);
    check_writes(8, 1, 0, 0, "drop");
    chk("drop ERR_DROP", ERR_DROP, 1);

    do_reset();
    run = 0;
    prev_a = -1;
    e_len = 1'b0;
    e_plane = 1'b0;
    e_fd = 0;
    for (int i = 0; i < 24; i++) begin
      n = ($urandom_range(0, 1) == 1) ? 8 : int'($urandom_range(0, 11));
      if (prev_a >= 0 && $urandom_range(0, 99) < 60)
        a = prev_a;
      else
        a = int'($urandom_range(0, 3));
      run = (a == prev_a) ? run + 1 : 0;
      prev_a = a;
      p = (run > 3) ? 3 : run;
      ewr = (p == 3) ? 0 : ((n > W) ? W : n);
      if (n != W) e_len = 1'b1;
      if (p == 3) e_plane = 1'b1;
      if (ewr > 0 && p == 2 && a == 3) e_fd++;
      send_line(n, a, 0);
      repeat (30) @(negedge CLK);
      check_writes(ewr, a, p, (p == 2 && a == 3),
                   $sformatf("rnd%0d", i));
    end
    chk("rnd ERR_LEN", ERR_LEN, e_len);
    chk("rnd ERR_PLANE", ERR_PLANE, e_plane);
    chk("rnd ERR_DROP", ERR_DROP, 0);
    chk("rnd frame_done count", fd_cnt, e_fd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
